// File: rtl/rr_grant_seq_pkg.sv
// rr_pkg: shared sizes and state type for the round-robin grant sequencer (N_REQ, IDX_W, state_t)
package rr_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_grant_seq_pick.sv
// rr_pick: rotate-priority search; req/ptr in, any (some request) and idx (first set bit from ptr upward, mod N_REQ) out
module rr_pick
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  assign any = |req;
  always_comb begin
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[ptr + IDX_W'(k)]) idx = ptr + IDX_W'(k);
  end
endmodule

// File: rtl/rr_grant_seq.sv
// rr_grant_seq: 4-way round-robin grant sequencer; clk/rst, req/done in, gnt_valid/gnt_idx/busy out, timeout out when RR_TIMEOUT_EN is defined
module rr_grant_seq
  import rr_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
`ifdef RR_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end
  state_t st, st_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n, pick_idx;
  logic any, rel, force_rel;
  rr_pick u_pick (.req(req), .ptr(ptr), .any(any), .idx(pick_idx));
  assign rel = done | ~req[gnt_idx];
`ifdef RR_TIMEOUT_EN
  logic [7:0] cnt;
  assign force_rel = ~rel & (cnt == 8'(HOLD_MAX - 1));
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= (st == GRANT) ? cnt + 8'd1 : 8'd0;
      timeout <= (st == GRANT) & force_rel;
    end
`else
  assign force_rel = 1'b0;
`endif
  always_comb begin
    st_n = st;
    ptr_n = ptr;
    idx_n = gnt_idx;
    if (st == IDLE && any) begin
      st_n = GRANT;
      idx_n = pick_idx;
    end else if (st == GRANT && (rel || force_rel)) begin
      st_n = IDLE;
      ptr_n = gnt_idx + IDX_W'(1);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      gnt_idx <= '0;
    end else begin
      st <= st_n;
      ptr <= ptr_n;
      gnt_idx <= idx_n;
    end
  assign gnt_valid = (st == GRANT);
  assign busy = gnt_valid;
endmodule
